dsu_host_controller: RTL and testbench

DSU_HOST_CONTROLLER -- requirements
Module: dsu_host_controller

---
 rtl/dsu_host_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_dsu_host_controller.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsu_host_controller.sv
// Host-side debug command controller: accepts one command at a time, drives the
// core's debug controls and returns one response per command or halt event.
module dsu_host_controller #(
    parameter  int THREAD_NUMB = 4,
    localparam int TID_W       = (THREAD_NUMB > 1) ? $clog2(THREAD_NUMB) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [3:0]                   cmd_opcode,
    input  logic [2:0]                   cmd_index,
    input  logic [31:0]                  cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_data,
    output logic                         rsp_error,
    output logic                         rsp_event,
    output logic                         dsu_enable,
    output logic                         dsu_single_step,
    output logic                         dsu_thread_selection,
    output logic [TID_W-1:0]             dsu_thread_id,
    output logic [7:0][31:0]             dsu_breakpoint,
    output logic [7:0]                   dsu_breakpoint_enable,
    output logic                         resume,
    output logic                         ext_freeze,
    input  logic                         freeze,
    input  logic                         dsu_hit_breakpoint,
    input  logic [THREAD_NUMB-1:0][31:0] dsu_bp_instruction,
    input  logic [TID_W-1:0]             dsu_bp_thread_id
);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WAIT_HALT, S_WAIT_RUN, S_RESPOND} state_e;
    typedef enum logic [3:0] {
        OP_NOP, OP_ENABLE, OP_DISABLE, OP_SET_BP, OP_CLR_BP, OP_SEL_THREAD,
        OP_UNSEL_THREAD, OP_STEP, OP_RESUME, OP_HALT, OP_STATUS, OP_READ_PC
    } opcode_e;

    state_e          state_q, state_d;
    opcode_e         op_q, op_d;
    logic [2:0]      idx_q, idx_d;
    logic [31:0]     data_q, data_d;
    logic            enable_q, enable_d, step_q, step_d, tsel_q, tsel_d;
    logic [TID_W-1:0] tid_q, tid_d;
    logic [7:0][31:0] bp_q, bp_d;
    logic [7:0]      bp_en_q, bp_en_d;
    logic            ext_freeze_q, ext_freeze_d, resume_q, resume_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_error_q, rsp_error_d, rsp_event_q, rsp_event_d;
    logic            pending_q, pending_d;
    logic            freeze_q, primed_q;
    logic [9:0]      timeout_q, timeout_d;
    logic            freeze_rise, tid_ok;

    // The edge detector is only trusted once it has sampled freeze after reset.
    assign freeze_rise = primed_q && freeze && !freeze_q;
    assign tid_ok      = data_q < 32'(THREAD_NUMB);
    assign cmd_ready   = reset_n && (state_q == S_IDLE) && !pending_q;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        state_d      = state_q;
        op_d         = op_q;
        idx_d        = idx_q;
        data_d       = data_q;
        enable_d     = enable_q;
        step_d       = step_q;
        tsel_d       = tsel_q;
        tid_d        = tid_q;
        bp_d         = bp_q;
        bp_en_d      = bp_en_q;
        ext_freeze_d = ext_freeze_q;
        resume_d     = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_error_d  = rsp_error_q;
        rsp_event_d  = rsp_event_q;
        pending_d    = pending_q;
        timeout_d    = timeout_q;

        if (freeze_rise && state_q != S_WAIT_HALT) pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = opcode_e'(cmd_opcode);
                    idx_d   = cmd_index;
                    data_d  = cmd_data;
                    state_d = S_EXEC;
                end else if (pending_q) begin
                    pending_d   = 1'b0;
                    rsp_data_d  = dsu_bp_instruction[dsu_bp_thread_id];
                    rsp_error_d = 1'b0;
                    rsp_event_d = 1'b1;
                    state_d     = S_RESPOND;
                end
            end
            S_EXEC: begin
                state_d     = S_RESPOND;
                rsp_data_d  = '0;
                rsp_error_d = 1'b0;
                rsp_event_d = 1'b0;
                case (op_q)
                    OP_NOP:          ;
                    OP_ENABLE:       enable_d = 1'b1;
                    OP_DISABLE: begin
                        enable_d     = 1'b0;
                        ext_freeze_d = 1'b0;
                    end
                    OP_SET_BP: begin
                        bp_d[idx_q]    = data_q;
                        bp_en_d[idx_q] = 1'b1;
                    end
                    OP_CLR_BP:       bp_en_d[idx_q] = 1'b0;
                    OP_SEL_THREAD: begin
                        if (tid_ok) begin
                            tid_d  = data_q[TID_W-1:0];
                            tsel_d = 1'b1;
                        end else begin
                            rsp_error_d = 1'b1;
                        end
                    end
                    OP_UNSEL_THREAD: tsel_d = 1'b0;
                    OP_STEP:         step_d = data_q[0];
                    OP_RESUME: begin
                        if (freeze) begin
                            resume_d = 1'b1;
                            state_d  = S_WAIT_RUN;
                        end else begin
                            rsp_error_d = 1'b1;
                        end
                    end
                    OP_HALT: begin
                        if (!enable_q || tsel_q) begin
                            rsp_error_d = 1'b1;
                        end else if (!freeze) begin
                            ext_freeze_d = 1'b1;
                            timeout_d    = '0;
                            state_d      = S_WAIT_HALT;
                        end
                    end
                    OP_STATUS: rsp_data_d = {16'h0, 8'(dsu_bp_thread_id), 3'b0,
                                             dsu_hit_breakpoint, freeze, tsel_q, step_q, enable_q};
                    OP_READ_PC: begin
                        if (tid_ok) rsp_data_d = dsu_bp_instruction[data_q[TID_W-1:0]];
                        else        rsp_error_d = 1'b1;
                    end
                    default:         rsp_error_d = 1'b1;
                endcase
            end
            S_WAIT_HALT: begin
                if (freeze || &timeout_q) begin
                    ext_freeze_d = 1'b0;
                    rsp_error_d  = !freeze;
                    state_d      = S_RESPOND;
                end else begin
                    timeout_d = timeout_q + 10'd1;
                end
            end
            S_WAIT_RUN: begin
                if (!freeze) state_d = S_RESPOND;
            end
            S_RESPOND: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NOP;
            idx_q        <= '0;
            data_q       <= '0;
            enable_q     <= 1'b0;
            step_q       <= 1'b0;
            tsel_q       <= 1'b0;
            tid_q        <= '0;
            // NOTE: the breakpoint file is architecturally visible, so it is reset like any register.
            bp_q         <= '0;
            bp_en_q      <= '0;
            ext_freeze_q <= 1'b0;
            resume_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
            rsp_event_q  <= 1'b0;
            pending_q    <= 1'b0;
            freeze_q     <= 1'b0;
            primed_q     <= 1'b0;
            timeout_q    <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register reading pre-edge values.
            state_q      <= state_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            enable_q     <= enable_d;
            step_q       <= step_d;
            tsel_q       <= tsel_d;
            tid_q        <= tid_d;
            bp_q         <= bp_d;
            bp_en_q      <= bp_en_d;
            ext_freeze_q <= ext_freeze_d;
            resume_q     <= resume_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
            rsp_event_q  <= rsp_event_d;
            pending_q    <= pending_d;
            freeze_q     <= freeze;
            primed_q     <= 1'b1;
            timeout_q    <= timeout_d;
        end
    end

    assign rsp_valid             = (state_q == S_RESPOND);
    assign rsp_data              = rsp_data_q;
    assign rsp_error             = rsp_error_q;
    assign rsp_event             = rsp_event_q;
    assign dsu_enable            = enable_q;
    assign dsu_single_step       = step_q;
    assign dsu_thread_selection  = tsel_q;
    assign dsu_thread_id         = tid_q;
    assign dsu_breakpoint        = bp_q;
    assign dsu_breakpoint_enable = bp_en_q;
    assign resume                = resume_q;
    assign ext_freeze            = ext_freeze_q;

endmodule

// File: tb/tb_dsu_host_controller.sv
// Directed bench for dsu_host_controller: a behavioural model predicts every
// response and the debug-control state it must be seen with.
module tb_dsu_host_controller;

    localparam int TN = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0, cmd_ready;
    logic [3:0]        cmd_opcode = '0;
    logic [2:0]        cmd_index = '0;
    logic [31:0]       cmd_data = '0;
    logic              rsp_valid, rsp_ready = 1'b1;
    logic [31:0]       rsp_data;
    logic              rsp_error, rsp_event;
    logic              dsu_enable, dsu_single_step, dsu_thread_selection;
    logic [1:0]        dsu_thread_id;
    logic [7:0][31:0]  dsu_breakpoint;
    logic [7:0]        dsu_breakpoint_enable;
    logic              resume, ext_freeze;
    logic              freeze = 1'b0, dsu_hit_breakpoint = 1'b0;
    logic [TN-1:0][31:0] bp_inst;
    logic [1:0]        bp_tid = '0;

    dsu_host_controller #(.THREAD_NUMB(TN)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_index(cmd_index), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_event(rsp_event),
        .dsu_enable(dsu_enable), .dsu_single_step(dsu_single_step),
        .dsu_thread_selection(dsu_thread_selection), .dsu_thread_id(dsu_thread_id),
        .dsu_breakpoint(dsu_breakpoint), .dsu_breakpoint_enable(dsu_breakpoint_enable),
        .resume(resume), .ext_freeze(ext_freeze),
        .freeze(freeze), .dsu_hit_breakpoint(dsu_hit_breakpoint),
        .dsu_bp_instruction(bp_inst), .dsu_bp_thread_id(bp_tid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        evt;
    } rsp_t;

    rsp_t        exp_q[$];
    int          n_checks = 0, n_pass = 0;
    int          resume_cnt = 0, xf_cnt = 0;
    bit          m_en, m_step, m_sel, halt_timeout;
    logic [1:0]  m_tid;
    logic [31:0] m_bp[8];
    logic [7:0]  m_bpen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        $display("FAIL %s: got no response within the cycle budget, expected one", name);
    endtask

    function automatic void model_reset();
        m_en = 0; m_step = 0; m_sel = 0; m_tid = '0; m_bpen = '0;
        for (int i = 0; i < 8; i++) m_bp[i] = '0;
    endfunction

    // Applies the command's architectural effect and queues the response it must produce.
    function automatic void model_cmd(input int op, input int idx, input logic [31:0] data);
        rsp_t r = '0;
        case (op)
            0: ;
            1: m_en = 1;
            2: m_en = 0;
            3: begin m_bp[idx] = data; m_bpen[idx] = 1'b1; end
            4: m_bpen[idx] = 1'b0;
            5: if (data < TN) begin m_tid = data[1:0]; m_sel = 1; end else r.err = 1;
            6: m_sel = 0;
            7: m_step = data[0];
            8: r.err = !freeze;
            9: if (!m_en || m_sel) r.err = 1; else if (!freeze) r.err = halt_timeout;
            10: r.data = 32'(bp_tid) * 256 + 32'(dsu_hit_breakpoint) * 16 + 32'(freeze) * 8
                        + 32'(m_sel) * 4 + 32'(m_step) * 2 + 32'(m_en);
            11: if (data < TN) r.data = bp_inst[data[1:0]]; else r.err = 1;
            default: r.err = 1;
        endcase
        exp_q.push_back(r);
    endfunction

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input int op, input int idx, input logic [31:0] data);
        bit ok = 0;
        model_cmd(op, idx, data);
        cmd_opcode = 4'(op); cmd_index = 3'(idx); cmd_data = data; cmd_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (cmd_ready) ok = 1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!ok) bound_fail("cmd_accept");
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            if (exp_q.size() == 0 && !rsp_valid) done = 1;
            else begin @(posedge clk); #1; end
        end
        if (!done) bound_fail("rsp_drain");
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic cmd(input int op, input int idx, input logic [31:0] data);
        send(op, idx, data);
        wait_idle(2000);
    endtask

    // Every response cycle is checked against the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rsp: got data %0h evt %0b, expected no response", rsp_data, rsp_event);
            end else begin
                check("rsp_data", rsp_data, exp_q[0].data);
                check("rsp_error", rsp_error, exp_q[0].err);
                check("rsp_event", rsp_event, exp_q[0].evt);
                check("cmd_ready_in_rsp", cmd_ready, 0);
                check("dsu_enable", dsu_enable, m_en);
                check("dsu_single_step", dsu_single_step, m_step);
                check("dsu_thread_selection", dsu_thread_selection, m_sel);
                check("dsu_thread_id", dsu_thread_id, m_tid);
                check("dsu_bp_enable", dsu_breakpoint_enable, m_bpen);
                for (int i = 0; i < 8; i++) check("dsu_breakpoint", dsu_breakpoint[i], m_bp[i]);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (resume) resume_cnt++;
        if (ext_freeze) xf_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bp_inst[0] = 32'h0000_1000; bp_inst[1] = 32'h0000_1234;
        bp_inst[2] = 32'h0000_0400; bp_inst[3] = 32'h0000_3000;
        model_reset();

        // Reset state
        #12;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ext_freeze", ext_freeze, 0);
        check("rst_resume", resume, 0);
        check("rst_enable", dsu_enable, 0);
        check("rst_bp_enable", dsu_breakpoint_enable, 0);
        check("rst_bp_any", |dsu_breakpoint, 0);
        check("rst_thread_id", dsu_thread_id, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", cmd_ready, 1);

        // ENABLE then SET_BP slot 3
        cmd(1, 0, 0);
        cmd(3, 3, 32'h400);
        check("bp3_value", dsu_breakpoint[3], 32'h400);
        check("bp_enable_08", dsu_breakpoint_enable, 8'h08);
        check("enable_set", dsu_enable, 1);

        // Unsolicited halt event, then RESUME
        bp_tid = 2'd2; dsu_hit_breakpoint = 1'b1;
        exp_q.push_back('{32'h400, 1'b0, 1'b1});
        freeze = 1'b1;
        wait_idle(100);
        resume_cnt = 0;
        send(8, 0, 0);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (resume) seen = 1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) bound_fail("resume_pulse");
        repeat (3) begin
            @(posedge clk); #1;
            check("no_rsp_while_frozen", rsp_valid, 0);
        end
        freeze = 1'b0;
        wait_idle(100);
        check("resume_pulse_cycles", resume_cnt, 1);

        // STATUS held by rsp_ready=0 for 5 cycles; freeze toggles twice meanwhile
        rsp_ready = 1'b0;
        send(10, 0, 0);
        check("status_model", exp_q[0].data, 32'h0000_0211);
        exp_q.push_back('{32'h400, 1'b0, 1'b1});
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (rsp_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) bound_fail("status_valid");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", rsp_valid, 1);
            check("stall_data", rsp_data, 32'h0000_0211);
            check("stall_ready", cmd_ready, 0);
            if (i < 3) freeze = (i != 1);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        wait_idle(100);
        freeze = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Thread select, bad opcodes, PC reads, breakpoint clear
        cmd(7, 0, 1);
        cmd(5, 0, TN);
        check("sel_unchanged", dsu_thread_selection, 0);
        cmd(13, 0, 0);
        cmd(5, 0, 1);
        cmd(11, 0, 1);
        cmd(11, 0, 7);
        send(10, 0, 0);
        check("status2_model", exp_q[0].data, 32'h0000_0217);
        wait_idle(100);
        cmd(9, 0, 0);
        cmd(6, 0, 0);
        cmd(4, 3, 0);
        check("bp3_kept", dsu_breakpoint[3], 32'h400);
        check("bp_enable_cleared", dsu_breakpoint_enable, 8'h00);
        cmd(0, 0, 32'h55);
        cmd(7, 0, 0);

        // HALT timeout
        halt_timeout = 1; xf_cnt = 0;
        cmd(9, 0, 0);
        check("timeout_xf_cycles", xf_cnt, 1024);
        check("timeout_xf_low", ext_freeze, 0);

        // HALT answered by freeze, then HALT while already frozen
        halt_timeout = 0;
        send(9, 0, 0);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (ext_freeze) seen = 1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) bound_fail("ext_freeze_rise");
        repeat (5) begin @(posedge clk); #1; end
        freeze = 1'b1;
        wait_idle(100);
        check("halt_xf_low", ext_freeze, 0);
        xf_cnt = 0;
        cmd(9, 0, 0);
        check("frozen_halt_no_xf", xf_cnt, 0);
        freeze = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Command and halt event in the same cycle: command first
        check("ready_before_race", cmd_ready, 1);
        model_cmd(0, 0, 0);
        exp_q.push_back('{32'h400, 1'b0, 1'b1});
        cmd_opcode = 4'd0; cmd_valid = 1'b1; freeze = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle(100);
        freeze = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // DISABLE blocks HALT
        cmd(2, 0, 0);
        cmd(9, 0, 0);
        cmd(1, 0, 0);

        // Reset while waiting for halt
        halt_timeout = 1;
        send(9, 0, 0);
        repeat (20) begin @(posedge clk); #1; end
        check("wh_xf_high", ext_freeze, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_xf", ext_freeze, 0);
        check("rst_mid_valid", rsp_valid, 0);
        check("rst_mid_resume", resume, 0);
        exp_q.delete();
        model_reset();
        @(posedge clk); #1;
        check("rst_mid_enable", dsu_enable, 0);
        reset_n = 1'b1;
        repeat (30) begin @(posedge clk); #1; end
        check("post_rst_xf", ext_freeze, 0);
        check("post_rst_ready", cmd_ready, 1);

        // Freeze already high at reset release raises no event
        reset_n = 1'b0; freeze = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check("no_event_on_release", cmd_ready, 1);
        freeze = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
